multdiv_issue: RTL and testbench
================================

MULTDIV_ISSUE -- requirements
Module: multdiv_issue

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: max cycles in BUSY awaiting data_resultRDY before forced exception; legal range 1..127.
REQ-002 clock  input  1  single system clock; all state updates on rising edge.
REQ-003 ctrl_reset  input  1  reset, asynchronous, active-low.
REQ-004 start_mult  input  1  pipeline request: multiply opA x opB.
REQ-005 start_div  input  1  pipeline request: divide opA / opB.
REQ-006 opA  input  32  first operand from register read.
REQ-007 opB  input  16  second operand from register read.
REQ-008 dest_reg  input  5  destination register index for writeback.
REQ-009 data_operandA  output  32  latched opA to multdiv.
REQ-010 data_operandB  output  16  latched opB to multdiv.
REQ-011 ctrl_MULT  output  1  one-cycle multiply start pulse to multdiv.
REQ-012 ctrl_DIV  output  1  one-cycle divide start pulse to multdiv.
REQ-013 data_result  input  32  result from multdiv.
REQ-014 data_exception  input  1  overflow / divide-by-zero from multdiv.
REQ-015 data_inputRDY  input  1  multdiv can accept a new operation.
REQ-016 data_resultRDY  input  1  multdiv result valid this cycle.
REQ-017 stall  output  1  freeze pipeline front end.
REQ-018 wb_en  output  1  one-cycle register-file write strobe.
REQ-019 wb_reg  output  5  register index for write.
REQ-020 wb_data  output  32  value to write.
REQ-021 wb_exception  output  1  operation ended in exception or timeout; valid with the WB cycle.

Function
REQ-022 FSM states SHALL be IDLE, ISSUE, BUSY, WB; stall SHALL equal (state != IDLE), registered-state decode.
REQ-023 IDLE: on start_mult or start_div, latch opA, opB, dest_reg, op type into internal registers, go ISSUE next cycle; both starts asserted -> multiply wins, divide discarded.
REQ-024 start_mult/start_div in any state other than IDLE SHALL be ignored.
REQ-025 ISSUE: hold while data_inputRDY=0; when data_inputRDY=1, assert exactly one of ctrl_MULT/ctrl_DIV (by latched op type) for exactly that one cycle, clear timeout counter, go BUSY.
REQ-026 data_operandA/B SHALL present latched operands continuously from ISSUE through WB, stable, unchanged by opA/opB inputs.
REQ-027 data_resultRDY observed in ISSUE SHALL be ignored (stale).
REQ-028 BUSY: 7-bit counter increments each cycle; on data_resultRDY=1, capture data_result and data_exception, go WB.
REQ-029 BUSY: counter reaching TIMEOUT_CYCLES without data_resultRDY -> wb_data=0, wb_exception=1, go WB; resultRDY in the same cycle as timeout SHALL win (result captured normally).
REQ-030 WB: one cycle; wb_reg=latched dest; wb_data=captured result, forced 0 when exception; wb_exception per capture; then IDLE.
REQ-031 wb_en SHALL pulse in WB only when latched dest != 0; wb_exception still reported when dest=0.
REQ-032 Outside WB: wb_en=0, wb_exception=0; wb_reg, wb_data hold last values.
REQ-033 Minimum latency start -> wb_en: 3 cycles plus multdiv compute time (IDLE->ISSUE->BUSY->WB).

Reset
REQ-034 ctrl_reset=0 SHALL immediately force state IDLE, counter 0, all latched registers 0, and outputs ctrl_MULT=0, ctrl_DIV=0, stall=0, wb_en=0, wb_exception=0, wb_reg=0, wb_data=0, data_operandA=0, data_operandB=0.
REQ-035 Reset mid-operation SHALL abandon the operation with no writeback; first start after release behaves as from power-up.

Verification
REQ-036 start_mult, opA=7, opB=6, dest=3, multdiv resultRDY=1 with 42 five cycles after pulse -> one ctrl_MULT pulse, stall high throughout, wb_en one cycle, wb_reg=3, wb_data=42, wb_exception=0.
REQ-037 start_div, opB=0, multdiv returns data_exception=1 -> ctrl_DIV pulse only, wb_exception=1, wb_data=0, wb_en=1.
REQ-038 data_inputRDY low 4 cycles in ISSUE -> no ctrl pulse until inputRDY rises; operands stable; stall stays 1.
REQ-039 TIMEOUT_CYCLES=8, no resultRDY -> WB after 8 BUSY cycles, wb_exception=1, wb_data=0; resultRDY on cycle 8 -> normal result instead.
REQ-040 start_mult and start_div together, dest=0 -> ctrl_MULT only, wb_en stays 0; new start during BUSY ignored.
REQ-041 ctrl_reset low during BUSY -> all outputs 0 asynchronously, no wb_en after release.

Source files
------------

// File: rtl/multdiv_issue.sv
// Issue/writeback sequencer in front of a multi-cycle multiply/divide unit.
// Latches one request, hands it to multdiv, waits for the result or a timeout, then writes back.
module multdiv_issue #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        start_mult,
  input  logic        start_div,
  input  logic [31:0] opA,
  input  logic [15:0] opB,
  input  logic [4:0]  dest_reg,
  output logic [31:0] data_operandA,
  output logic [15:0] data_operandB,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  input  logic [31:0] data_result,
  input  logic        data_exception,
  input  logic        data_inputRDY,
  input  logic        data_resultRDY,
  output logic        stall,
  output logic        wb_en,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        wb_exception
);

  localparam int unsigned A_W   = 32;
  localparam int unsigned B_W   = 16;
  localparam int unsigned R_W   = 5;
  localparam int unsigned CNT_W = 7;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;
  localparam logic [1:0] S_WB    = 2'd3;

  // Counter value seen during the last permitted BUSY cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [A_W-1:0]   op_a;
  logic [B_W-1:0]   op_b;
  logic [R_W-1:0]   dest;
  logic             op_mult;
  logic             start_any;
  logic             timeout;
  logic             finish;
  logic             launch;

  assign start_any     = start_mult | start_div;
  assign timeout       = (cnt == CNT_LAST);
  assign stall         = (state != S_IDLE);
  assign data_operandA = op_a;
  assign data_operandB = op_b;

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Start pulses are a same-cycle handshake with data_inputRDY while in ISSUE.
  always_comb begin
    state_nxt = state;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    finish    = 1'b0;
    launch    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_any) begin
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (data_inputRDY) begin
          launch    = 1'b1;
          ctrl_MULT = op_mult;
          ctrl_DIV  = ~op_mult;
          state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (data_resultRDY || timeout) begin
          finish    = 1'b1;
          state_nxt = S_WB;
        end
      end
      S_WB: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Request latch, timeout counter and writeback registers.
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      op_a         <= '0;
      op_b         <= '0;
      dest         <= '0;
      op_mult      <= 1'b0;
      cnt          <= '0;
      wb_en        <= 1'b0;
      wb_exception <= 1'b0;
      wb_reg       <= '0;
      wb_data      <= '0;
    end else begin
      wb_en        <= 1'b0;
      wb_exception <= 1'b0;

      if ((state == S_IDLE) && start_any) begin
        op_a    <= opA;
        op_b    <= opB;
        dest    <= dest_reg;
        op_mult <= start_mult;
      end

      if (launch) begin
        cnt <= '0;
      end else if (state == S_BUSY) begin
        cnt <= cnt + CNT_W'(1);
      end

      // A result arriving on the timeout cycle takes precedence over the timeout.
      if (finish) begin
        wb_en  <= (dest != '0);
        wb_reg <= dest;
        if (data_resultRDY) begin
          wb_exception <= data_exception;
          wb_data      <= data_exception ? '0 : data_result;
        end else begin
          wb_exception <= 1'b1;
          wb_data      <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_multdiv_issue.sv
// Directed bench for multdiv_issue: a per-cycle reference model plus hand-computed literal checks.
module tb_multdiv_issue;

  localparam int unsigned TMO = 8;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        start_mult;
  logic        start_div;
  logic [31:0] opA;
  logic [15:0] opB;
  logic [4:0]  dest_reg;
  logic [31:0] data_operandA;
  logic [15:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_inputRDY;
  logic        data_resultRDY;
  logic        stall;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        wb_exception;

  always #5 clock = ~clock;

  multdiv_issue #(.TIMEOUT_CYCLES(TMO)) dut (
    .clock          (clock),
    .ctrl_reset     (ctrl_reset),
    .start_mult     (start_mult),
    .start_div      (start_div),
    .opA            (opA),
    .opB            (opB),
    .dest_reg       (dest_reg),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_inputRDY  (data_inputRDY),
    .data_resultRDY (data_resultRDY),
    .stall          (stall),
    .wb_en          (wb_en),
    .wb_reg         (wb_reg),
    .wb_data        (wb_data),
    .wb_exception   (wb_exception)
  );

  int vectors     = 0;
  int miscompares = 0;
  int n_mult      = 0;
  int n_div       = 0;
  int base_m      = 0;
  int base_d      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an operation is open from acceptance until its writeback cycle.
  bit          m_open;
  bit          m_issued;
  bit          m_wb;
  bit          m_exc;
  bit          m_op_mult;
  bit          in_issue;
  logic [31:0] m_a;
  logic [15:0] m_b;
  logic [4:0]  m_dest;
  int unsigned m_busy_n;
  logic [4:0]  m_wb_reg;
  logic [31:0] m_wb_data;

  initial begin
    m_open = 0; m_issued = 0; m_wb = 0; m_exc = 0; m_op_mult = 0;
    m_a = '0; m_b = '0; m_dest = '0; m_busy_n = 0; m_wb_reg = '0; m_wb_data = '0;
  end

  always @(negedge clock) begin
    if (!ctrl_reset) begin
      m_open = 0; m_issued = 0; m_wb = 0; m_exc = 0; m_op_mult = 0;
      m_a = '0; m_b = '0; m_dest = '0; m_busy_n = 0; m_wb_reg = '0; m_wb_data = '0;
    end
    in_issue = m_open && !m_issued;
    check("stall",        32'(stall),         32'(m_open));
    check("operand_a",    data_operandA,       m_a);
    check("operand_b",    32'(data_operandB),  32'(m_b));
    check("ctrl_mult",    32'(ctrl_MULT),      32'(in_issue && data_inputRDY && m_op_mult));
    check("ctrl_div",     32'(ctrl_DIV),       32'(in_issue && data_inputRDY && !m_op_mult));
    check("wb_en",        32'(wb_en),          32'(m_wb && (m_dest != 5'd0)));
    check("wb_exception", 32'(wb_exception),   32'(m_wb && m_exc));
    check("wb_reg",       32'(wb_reg),         32'(m_wb_reg));
    check("wb_data",      wb_data,             m_wb_data);
    if (ctrl_MULT) n_mult++;
    if (ctrl_DIV)  n_div++;

    if (ctrl_reset) begin
      if (m_wb) begin
        m_wb   = 0;
        m_open = 0;
      end else if (!m_open) begin
        if (start_mult || start_div) begin
          m_open    = 1;
          m_issued  = 0;
          m_a       = opA;
          m_b       = opB;
          m_dest    = dest_reg;
          m_op_mult = start_mult;
        end
      end else if (!m_issued) begin
        if (data_inputRDY) begin
          m_issued = 1;
          m_busy_n = 0;
        end
      end else begin
        m_busy_n++;
        if (data_resultRDY) begin
          m_wb      = 1;
          m_exc     = data_exception;
          m_wb_data = data_exception ? 32'd0 : data_result;
          m_wb_reg  = m_dest;
        end else if (m_busy_n == TMO) begin
          m_wb      = 1;
          m_exc     = 1;
          m_wb_data = 32'd0;
          m_wb_reg  = m_dest;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic idle_inputs();
    start_mult     = 1'b0;
    start_div      = 1'b0;
    data_inputRDY  = 1'b1;
    data_resultRDY = 1'b0;
    data_result    = 32'd0;
    data_exception = 1'b0;
  endtask

  task automatic snapshot();
    base_m = n_mult;
    base_d = n_div;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ctrl_reset = 1'b0;
    opA = '0; opB = '0; dest_reg = '0;
    idle_inputs();
    tick(2);
    check("rst_stall",   32'(stall), 32'd0);
    check("rst_wb_data", wb_data,    32'd0);
    ctrl_reset = 1'b1;
    tick(1);

    // Multiply 7 x 6 -> r3, result five cycles after the start pulse.
    snapshot();
    start_mult = 1'b1; opA = 32'd7; opB = 16'd6; dest_reg = 5'd3;
    tick(1);
    start_mult = 1'b0; opA = 32'hFFFF_FFFF; opB = 16'hFFFF; dest_reg = 5'd31;
    tick(5);
    data_resultRDY = 1'b1; data_result = 32'd42;
    tick(1);
    check("s1_wb_en",   32'(wb_en),        32'd1);
    check("s1_wb_reg",  32'(wb_reg),       32'd3);
    check("s1_wb_data", wb_data,           32'd42);
    check("s1_wb_exc",  32'(wb_exception), 32'd0);
    check("s1_stall",   32'(stall),        32'd1);
    check("s1_pulses",  32'(n_mult - base_m), 32'd1);
    idle_inputs();
    tick(1);
    check("s1_hold",    wb_data,           32'd42);

    // Divide by zero reports the exception with zeroed data.
    snapshot();
    start_div = 1'b1; opA = 32'd100; opB = 16'd0; dest_reg = 5'd5;
    tick(1);
    start_div = 1'b0;
    tick(1);
    data_resultRDY = 1'b1; data_exception = 1'b1; data_result = 32'hDEAD_BEEF;
    tick(1);
    check("s2_wb_en",   32'(wb_en),        32'd1);
    check("s2_wb_exc",  32'(wb_exception), 32'd1);
    check("s2_wb_data", wb_data,           32'd0);
    check("s2_wb_reg",  32'(wb_reg),       32'd5);
    check("s2_div",     32'(n_div - base_d),  32'd1);
    check("s2_mult",    32'(n_mult - base_m), 32'd0);
    idle_inputs();
    tick(1);

    // multdiv not ready for four ISSUE cycles.
    snapshot();
    data_inputRDY = 1'b0;
    start_mult = 1'b1; opA = 32'h1234_5678; opB = 16'hABCD; dest_reg = 5'd7;
    tick(1);
    start_mult = 1'b0; opA = 32'd0; opB = 16'd0;
    tick(4);
    check("s3_no_pulse", 32'(n_mult - base_m), 32'd0);
    check("s3_opa",      data_operandA,        32'h1234_5678);
    check("s3_opb",      32'(data_operandB),   32'h0000_ABCD);
    check("s3_stall",    32'(stall),           32'd1);
    data_inputRDY = 1'b1;
    tick(1);
    check("s3_pulse",    32'(n_mult - base_m), 32'd1);
    data_resultRDY = 1'b1; data_result = 32'h0000_0102;
    tick(1);
    check("s3_wb_data",  wb_data,              32'h0000_0102);
    check("s3_wb_reg",   32'(wb_reg),          32'd7);
    idle_inputs();
    tick(1);

    // Timeout after eight BUSY cycles.
    start_mult = 1'b1; opA = 32'd3; opB = 16'd4; dest_reg = 5'd9;
    tick(1);
    start_mult = 1'b0;
    tick(8);
    check("s4_busy8_stall", 32'(stall), 32'd1);
    check("s4_busy8_wb",    32'(wb_en), 32'd0);
    tick(1);
    check("s4_wb_en",   32'(wb_en),        32'd1);
    check("s4_wb_exc",  32'(wb_exception), 32'd1);
    check("s4_wb_data", wb_data,           32'd0);
    check("s4_wb_reg",  32'(wb_reg),       32'd9);
    tick(1);

    // Result on the eighth BUSY cycle beats the timeout.
    start_mult = 1'b1; opA = 32'd11; opB = 16'd7; dest_reg = 5'd10;
    tick(1);
    start_mult = 1'b0;
    tick(8);
    data_resultRDY = 1'b1; data_result = 32'd77;
    tick(1);
    check("s4b_wb_exc",  32'(wb_exception), 32'd0);
    check("s4b_wb_data", wb_data,           32'd77);
    idle_inputs();
    tick(1);

    // Simultaneous starts to r0; new starts while BUSY are ignored.
    snapshot();
    start_mult = 1'b1; start_div = 1'b1; opA = 32'd2; opB = 16'd3; dest_reg = 5'd0;
    tick(1);
    start_mult = 1'b0; start_div = 1'b0;
    tick(1);
    start_mult = 1'b1; start_div = 1'b1; opA = 32'd55; dest_reg = 5'd12;
    tick(2);
    start_mult = 1'b0; start_div = 1'b0;
    data_resultRDY = 1'b1; data_result = 32'd5;
    tick(1);
    check("s5_wb_en",   32'(wb_en),        32'd0);
    check("s5_wb_exc",  32'(wb_exception), 32'd0);
    check("s5_wb_reg",  32'(wb_reg),       32'd0);
    check("s5_wb_data", wb_data,           32'd5);
    check("s5_opa",     data_operandA,     32'd2);
    check("s5_mult",    32'(n_mult - base_m), 32'd1);
    check("s5_div",     32'(n_div - base_d),  32'd0);
    idle_inputs();
    tick(1);
    check("s5_idle",    32'(stall),        32'd0);

    // Asynchronous reset in the middle of BUSY.
    start_mult = 1'b1; opA = 32'd8; opB = 16'd9; dest_reg = 5'd4;
    tick(1);
    start_mult = 1'b0;
    tick(2);
    #2 ctrl_reset = 1'b0;
    #1;
    check("s6_stall", 32'(stall),         32'd0);
    check("s6_mult",  32'(ctrl_MULT),     32'd0);
    check("s6_div",   32'(ctrl_DIV),      32'd0);
    check("s6_wb_en", 32'(wb_en),         32'd0);
    check("s6_exc",   32'(wb_exception),  32'd0);
    check("s6_reg",   32'(wb_reg),        32'd0);
    check("s6_data",  wb_data,            32'd0);
    check("s6_opa",   data_operandA,      32'd0);
    check("s6_opb",   32'(data_operandB), 32'd0);
    tick(2);
    ctrl_reset = 1'b1;
    data_resultRDY = 1'b1; data_result = 32'd123;
    tick(3);
    check("s6_no_wb",    32'(wb_en), 32'd0);
    check("s6_no_stall", 32'(stall), 32'd0);
    idle_inputs();

    // First operation after release behaves normally.
    start_mult = 1'b1; opA = 32'd10; opB = 16'd11; dest_reg = 5'd1;
    tick(1);
    start_mult = 1'b0;
    tick(1);
    data_resultRDY = 1'b1; data_result = 32'd110;
    tick(1);
    check("s7_wb_en",   32'(wb_en),  32'd1);
    check("s7_wb_data", wb_data,     32'd110);
    check("s7_wb_reg",  32'(wb_reg), 32'd1);
    idle_inputs();
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
